instr_fetch: RTL and testbench

Instruction fetch controller that sits between the program counter and instruction memory. It samples the current PC, issues word fetches to instruction memory over a valid/ready request channel, drives `pc_write`/`next_pc` back into the program counter, buffers returned instructions in a small fetch queue, and presents them to decode over a valid/ready channel. Branch redirects flush the queue and kill any in-flight fetch.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg: shared widths, FSM encoding and queue entry type. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue: synchronous FIFO of fetched {pc, instr}; flush beats push/pop. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  FQ_DEPTH = 2,
  localparam int AW       = $clog2(FQ_DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fq_entry_t     i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output fq_entry_t     o_head
);

  localparam logic [CW-1:0] c_FULL    = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  fq_entry_t     r_mem [FQ_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != c_FULL) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch: single-outstanding instruction fetch with redirect kill. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_write,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int            CW     = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] c_FULL = CW'(FQ_DEPTH);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_req_pc;

  logic [CW-1:0] w_count;
  fq_entry_t     w_head;
  fq_entry_t     w_push_data;
  logic          w_req_fire;
  logic          w_rsp_keep;
  logic          w_pop;

  assign imem_req_addr = {pc_in[ADDR_W-1:2], 2'b00};

  // Space check uses the registered count only: a same-cycle pop earns no credit.
  assign imem_req_valid = !rst && (r_state == IDLE) && (w_count < c_FULL) && !redirect_valid;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign pc_write = !rst & (redirect_valid | w_req_fire);
  assign next_pc  = redirect_valid ? redirect_pc : (pc_in + PC_INC);

  assign w_rsp_keep  = (r_state == WAIT) & imem_rsp_valid & !redirect_valid;
  assign w_push_data = '{pc: r_req_pc, instr: imem_rsp_data};

  assign if_valid = (w_count != '0);
  assign w_pop    = if_valid & if_ready;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_state  <= WAIT;
            r_req_pc <= pc_in;
          end
        end
        WAIT: begin
          // A response arriving with a redirect is simply dropped.
          if (imem_rsp_valid) begin
            r_state <= IDLE;
          end else if (redirect_valid) begin
            r_state <= KILL;
          end
        end
        KILL: begin
          if (imem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rsp_keep),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch: directed scoreboard bench for instr_fetch. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_write;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_req [$];
  logic [63:0] exp_if  [$];

  logic        rsp_auto;
  logic        cap_hs;
  logic        cap_pcw;
  logic [31:0] cap_addr;
  logic [31:0] cap_npc;
  event        ev_smp;

  instr_fetch #(.FQ_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_write       (pc_write),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One clock: sample settled outputs, let the monitor look, then play the
  // program counter and memory for the next cycle.
  task automatic cyc();
    cap_hs   = !rst && imem_req_valid && imem_req_ready;
    cap_addr = imem_req_addr;
    cap_pcw  = pc_write;
    cap_npc  = next_pc;
    -> ev_smp;
    @(negedge clk);
    if (cap_pcw) pc_in = cap_npc;
    imem_rsp_valid = cap_hs && rsp_auto;
    imem_rsp_data  = cap_hs ? mem_word(cap_addr) : 32'h0;
    redirect_valid = 1'b0;
    #2;
  endtask

  initial begin
    logic [31:0] er;
    logic [63:0] ei;
    forever begin
      @(ev_smp);
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL req_unexpected: got addr %h, required no request", imem_req_addr);
        end else begin
          er = exp_req.pop_front();
          chk("req_addr", {32'h0, imem_req_addr}, {32'h0, er});
        end
      end
      if (if_valid && if_ready) begin
        if (exp_if.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL if_unexpected: got pc %h instr %h, required no instruction", if_pc, if_instr);
        end else begin
          ei = exp_if.pop_front();
          chk("if_pc_instr", {if_pc, if_instr}, ei);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  bit t1_reqv [7]  = '{1, 0, 1, 0, 1, 0, 1};
  bit t1_ifv  [7]  = '{0, 0, 1, 0, 1, 0, 1};
  bit t2_rdy  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit t2_ifr  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
  bit t2_reqv [10] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 1};

  initial begin
    rst            = 1'b1;
    pc_in          = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    rsp_auto       = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_write",  pc_write, 0);
    chk("rst_if_valid",  if_valid, 0);
    chk("rst_if_instr",  if_instr, 0);
    chk("rst_if_pc",     if_pc, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("rst_pc_write_redir", pc_write, 0);
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Streaming fetch at 0, 4, 8
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_if.push_back({32'h0, 32'hC0DE0000});
    exp_if.push_back({32'h4, 32'hC0DE0004});
    exp_if.push_back({32'h8, 32'hC0DE0008});
    for (int k = 0; k < 7; k++) begin
      imem_req_ready = (k < 5);
      if_ready       = 1'b1;
      #1;
      chk($sformatf("t1_req_valid[%0d]", k), imem_req_valid, t1_reqv[k]);
      chk($sformatf("t1_if_valid[%0d]", k),  if_valid, t1_ifv[k]);
      if (k == 0) begin
        chk("t1_pc_write", pc_write, 1);
        chk("t1_next_pc",  next_pc, 32'h4);
      end
      cyc();
    end

    // Queue-full stall, then a one-cycle pop releases one request
    exp_req.push_back(32'hC);
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h14);
    exp_if.push_back({32'hC,  32'hC0DE000C});
    exp_if.push_back({32'h10, 32'hC0DE0010});
    exp_if.push_back({32'h14, 32'hC0DE0014});
    for (int j = 0; j < 10; j++) begin
      imem_req_ready = t2_rdy[j];
      if_ready       = t2_ifr[j];
      #1;
      chk($sformatf("t2_req_valid[%0d]", j), imem_req_valid, t2_reqv[j]);
      cyc();
    end
    #1;
    chk("t2_drained", if_valid, 0);

    // Redirect while WAIT with a non-empty queue
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    exp_req.push_back(32'h18);
    #1; cyc();
    #1; chk("t3_wait_no_req", imem_req_valid, 0); cyc();
    exp_req.push_back(32'h1C);
    rsp_auto = 1'b0;
    #1; chk("t3_second_req", imem_req_valid, 1); cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("t3_redir_pc_write", pc_write, 1);
    chk("t3_redir_next_pc",  next_pc, 32'h100);
    chk("t3_redir_no_req",   imem_req_valid, 0);
    chk("t3_pre_flush_valid", if_valid, 1);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEADBEEF;
    #1;
    chk("t3_flushed", if_valid, 0);
    chk("t3_kill_no_req", imem_req_valid, 0);
    cyc();
    rsp_auto = 1'b1;
    exp_req.push_back(32'h100);
    #1; chk("t3_req_target", imem_req_valid, 1); cyc();
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    exp_if.push_back({32'h100, 32'hC0DE0100});
    #1; chk("t3_killed_dropped", if_valid, 0); cyc();
    #1; chk("t3_target_valid", if_valid, 1); cyc();

    // Redirect coincident with a response and a decode pop
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    exp_req.push_back(32'h104);
    #1; cyc();
    imem_req_ready = 1'b0;
    #1; cyc();
    imem_req_ready = 1'b1;
    exp_req.push_back(32'h108);
    #1; chk("t4_head_valid", if_valid, 1); cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    if_ready       = 1'b1;
    exp_if.push_back({32'h104, 32'hC0DE0104});
    #1;
    chk("t4_redir_pc_write", pc_write, 1);
    chk("t4_redir_next_pc",  next_pc, 32'h200);
    chk("t4_redir_no_req",   imem_req_valid, 0);
    cyc();
    if_ready = 1'b0;
    exp_req.push_back(32'h200);
    #1;
    chk("t4_flushed", if_valid, 0);
    chk("t4_idle_req", imem_req_valid, 1);
    cyc();
    imem_req_ready = 1'b0;
    #1; chk("t4_nothing_enq", if_valid, 0); cyc();
    if_ready = 1'b1;
    exp_if.push_back({32'h200, 32'hC0DE0200});
    #1; chk("t4_target_valid", if_valid, 1); cyc();

    // PC wrap at the top of the address space
    pc_in          = 32'hFFFFFFFC;
    imem_req_ready = 1'b1;
    exp_req.push_back(32'hFFFFFFFC);
    #1;
    chk("t5_pc_write", pc_write, 1);
    chk("t5_next_pc_wrap", next_pc, 32'h0);
    cyc();
    imem_req_ready = 1'b0;
    exp_if.push_back({32'hFFFFFFFC, 32'hC0DEFFFC});
    #1; cyc();
    #1; chk("t5_valid", if_valid, 1); cyc();

    // Reset during WAIT; the late response must be ignored
    imem_req_ready = 1'b1;
    rsp_auto       = 1'b0;
    exp_req.push_back(32'h0);
    #1; cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_req_valid", imem_req_valid, 0);
    chk("t6_rst_pc_write",  pc_write, 0);
    chk("t6_rst_if_valid",  if_valid, 0);
    imem_req_ready = 1'b0;
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0BAD0;
    cyc();
    #1;
    chk("t6_if_valid_a", if_valid, 0);
    chk("t6_idle_req",   imem_req_valid, 1);
    cyc();
    #1; chk("t6_if_valid_b", if_valid, 0); cyc();

    chk("left_req", exp_req.size(), 0);
    chk("left_if",  exp_if.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
